// File: rtl/MD_pkg.sv
// Shared molecular-dynamics types and widths used by the force pipeline blocks.
package MD_pkg;

  localparam int PARTICLE_ID_WIDTH    = 7;
  localparam int FLOAT_STRUCT_WIDTH   = 96;
  localparam int FRC_CACHE_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] y;
    logic [31:0] x;
  } float_data_t;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] parid;
    float_data_t                  frc;
  } frc_cache_entry_t;

endpackage

// File: rtl/fp32_add_pipe.sv
// One fp32 adder lane: IEEE add, round-to-nearest-even, denormals flushed to zero.
// Result appears LATENCY cycles after the operands; no stall, no valid (tracked by the caller).
module fp32_add_pipe #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [26:0] mx, my, myf, n;
    logic [27:0] s;
    logic [24:0] mr;
    logic        sticky, up, found;
    int          d, e, lz;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    a_inf  = (&a[30:23]) && !(|a[22:0]);
    b_inf  = (&b[30:23]) && !(|b[22:0]);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC00000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d   = int'(x[30:23]) - int'(y[30:23]);
    mx  = {1'b1, x[22:0], 3'b000};
    myf = {1'b1, y[22:0], 3'b000};
    // Three extra bits (guard, round, sticky) are enough for RNE with a one-bit renormalise.
    if (d > 26) begin
      my     = 27'd0;
      sticky = 1'b1;
    end else begin
      my     = myf >> d;
      sticky = |(myf & ~({27{1'b1}} << d));
    end
    my[0] = my[0] | sticky;
    e     = int'(x[30:23]);
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        n = {s[27:2], s[1] | s[0]};
        e = e + 1;
      end else begin
        n = s[26:0];
      end
    end else begin
      s = {1'b0, mx} - {1'b0, my};
      n = s[26:0];
      if (n == 27'd0) return 32'd0;
      lz    = 0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (n[i]) found = 1'b1;
        else if (!found) lz++;
      end
      n = n << lz;
      e = e - lz;
    end
    up = n[2] & (n[1] | n[0] | n[3]);
    mr = {1'b0, n[26:3]} + {24'd0, up};
    if (mr[24]) e = e + 1;
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    if (e <= 0) return {x[31], 31'd0};
    return {x[31], e[7:0], mr[22:0]};
  endfunction

  logic [31:0] pipe_q [LATENCY];

  always_ff @(posedge clk) begin
    pipe_q[0] <= fp_add(a_i, b_i);
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign sum_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/force_cache_accum.sv
// Per-cell force cache: queues partial forces, accumulates them per particle by read-modify-write,
// and serves read-and-clear requests from motion update whenever the block is idle.
module force_cache_accum #(
  parameter int PARTICLE_ID_WIDTH  = MD_pkg::PARTICLE_ID_WIDTH,
  parameter int FLOAT_STRUCT_WIDTH = MD_pkg::FLOAT_STRUCT_WIDTH,
  parameter int ADD_LATENCY        = 3,
  parameter int FIFO_DEPTH         = MD_pkg::FRC_CACHE_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FLOAT_STRUCT_WIDTH-1:0] i_force,
  input  logic [PARTICLE_ID_WIDTH-1:0]  i_parid,
  input  logic                          i_force_valid,
  input  logic                          i_rd_req,
  input  logic [PARTICLE_ID_WIDTH-1:0]  i_rd_parid,
  output logic                          o_rd_ready,
  output logic [FLOAT_STRUCT_WIDTH-1:0] o_rd_force,
  output logic                          o_rd_valid,
  output logic                          o_idle,
  output logic                          o_fifo_full,
  output logic                          o_overflow
);

  import MD_pkg::*;

  localparam int DEPTH = 2 ** PARTICLE_ID_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NST   = ADD_LATENCY + 1;

  frc_cache_entry_t fifo_mem [FIFO_DEPTH];
  frc_cache_entry_t head, in_entry;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full, push, pop, hazard;

  logic [NST-1:0]               vld_q;
  logic [PARTICLE_ID_WIDTH-1:0] id_q [NST];
  logic [FLOAT_STRUCT_WIDTH-1:0] addend_q, operand, wr_data, rdata_q;
  logic [DEPTH-1:0]             bitmap_q, bitmap_d;
  logic [FLOAT_STRUCT_WIDTH-1:0] mem [DEPTH];
  logic                         hit_q, rd_vld_q, overflow_q;
  logic                         rd_acc, wr_en;
  logic [PARTICLE_ID_WIDTH-1:0] rd_addr, wr_addr;

  assign in_entry   = {i_parid, i_force};
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

  // Head waits while its particle is anywhere between read and write-back; no forwarding path.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NST; k++) begin
      if (vld_q[k] && (id_q[k] == head.parid)) hazard = 1'b1;
    end
  end

  assign pop      = !fifo_empty && !hazard;
  assign push     = i_force_valid && (!fifo_full || pop);
  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign o_idle      = fifo_empty && !(|vld_q);
  assign o_rd_ready  = o_idle;
  assign rd_acc      = i_rd_req && o_rd_ready;
  assign o_fifo_full = fifo_full;
  assign o_overflow  = overflow_q;
  assign o_rd_valid  = rd_vld_q;
  assign o_rd_force  = (rd_vld_q && hit_q) ? rdata_q : '0;

  // Readout only happens when idle, so issue and readout never compete for the read port.
  assign rd_addr = pop ? head.parid : i_rd_parid;
  assign wr_en   = vld_q[NST-1];
  assign wr_addr = id_q[NST-1];

  always_comb begin
    bitmap_d = bitmap_q;
    if (wr_en) bitmap_d[wr_addr] = 1'b1;
    if (rd_acc) bitmap_d[i_rd_parid] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_q      <= '0;
      bitmap_q   <= '0;
      overflow_q <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= {vld_q[NST-2:0], pop};
      bitmap_q <= bitmap_d;
      rd_vld_q <= rd_acc;
      if (i_force_valid && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= in_entry;
  end

  always_ff @(posedge clk) begin
    id_q[0]  <= head.parid;
    addend_q <= head.frc;
    for (int k = 1; k < NST; k++) id_q[k] <= id_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rdata_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    hit_q   <= bitmap_q[rd_addr];
  end

  assign operand = hit_q ? rdata_q : '0;

  for (genvar l = 0; l < 3; l++) begin : g_lane
    fp32_add_pipe #(
      .LATENCY(ADD_LATENCY)
    ) u_add (
      .clk  (clk),
      .a_i  (operand[32*l +: 32]),
      .b_i  (addend_q[32*l +: 32]),
      .sum_o(wr_data[32*l +: 32])
    );
  end

endmodule

// File: tb/tb_force_cache_accum.sv
// Directed bench for force_cache_accum: reads are scored by a queue-driven monitor.
module tb_force_cache_accum;
  import MD_pkg::*;

  localparam int LAT = 3;
  localparam int IDW = PARTICLE_ID_WIDTH;

  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] TWO   = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000;
  localparam logic [31:0] HALF  = 32'h3F000000;
  localparam logic [31:0] MHALF = 32'hBF000000;
  localparam logic [31:0] MONE  = 32'hBF800000;
  localparam logic [31:0] MTWO  = 32'hC0000000;

  logic           clk = 1'b0;
  logic           rst;
  logic [95:0]    i_force;
  logic [IDW-1:0] i_parid, i_rd_parid;
  logic           i_force_valid, i_rd_req;
  logic           o_rd_ready, o_rd_valid, o_idle, o_fifo_full, o_overflow;
  logic [95:0]    o_rd_force;

  always #5 clk = ~clk;

  force_cache_accum #(.ADD_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_force      (i_force),
    .i_parid      (i_parid),
    .i_force_valid(i_force_valid),
    .i_rd_req     (i_rd_req),
    .i_rd_parid   (i_rd_parid),
    .o_rd_ready   (o_rd_ready),
    .o_rd_force   (o_rd_force),
    .o_rd_valid   (o_rd_valid),
    .o_idle       (o_idle),
    .o_fifo_full  (o_fifo_full),
    .o_overflow   (o_overflow)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic saw_full = 1'b0;

  typedef struct {
    logic [95:0] val;
    int          cyc;
    int          id;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_fifo_full) saw_full = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (o_rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: o_rd_force=%h with no read outstanding", o_rd_force);
      end else begin
        e = exp_q.pop_front();
        if (o_rd_force !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL rd_id%0d: got %h at cycle %0d, required %h at cycle %0d",
                   e.id, o_rd_force, cyc, e.val, e.cyc);
        end
      end
    end
  end

  function automatic logic [95:0] f3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  function automatic logic [31:0] int2f(input int n);
    logic [31:0] u, m;
    int msb;
    if (n == 0) return 32'd0;
    u   = n;
    msb = 0;
    for (int i = 0; i < 24; i++) if (u[i]) msb = i;
    m = u << (23 - msb);
    return {1'b0, 8'(127 + msb), m[22:0]};
  endfunction

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic chk96(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push(input int id, input logic [95:0] f);
    i_force_valid = 1'b1;
    i_parid       = IDW'(id);
    i_force       = f;
    @(negedge clk);
    i_force_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!o_idle && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!o_idle) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: o_idle=%b after %0d cycles, required 1", o_idle, n);
    end
  endtask

  task automatic rd(input int id, input logic [95:0] expv);
    exp_t e;
    int   n;
    n = 0;
    while (!o_rd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!o_rd_ready) begin
      checks++;
      errors++;
      $display("FAIL rd_ready_timeout: o_rd_ready=%b for id %0d, required 1", o_rd_ready, id);
      return;
    end
    i_rd_req   = 1'b1;
    i_rd_parid = IDW'(id);
    @(posedge clk);
    #1;
    e.val = expv;
    e.cyc = cyc;
    e.id  = id;
    exp_q.push_back(e);
    @(negedge clk);
    i_rd_req = 1'b0;
  endtask

  initial begin
    int n;
    rst           = 1'b0;
    i_force       = '0;
    i_parid       = '0;
    i_force_valid = 1'b0;
    i_rd_req      = 1'b0;
    i_rd_parid    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk1("reset_idle", o_idle, 1'b1);
    chk1("reset_rd_ready", o_rd_ready, 1'b1);
    chk1("reset_fifo_full", o_fifo_full, 1'b0);
    chk1("reset_overflow", o_overflow, 1'b0);
    chk1("reset_rd_valid", o_rd_valid, 1'b0);
    chk96("reset_rd_force", o_rd_force, 96'd0);
    rd(5, 96'd0);

    push(3, f3(ONE, TWO, MHALF));
    wait_idle(n);
    rd(3, f3(ONE, TWO, MHALF));
    rd(3, 96'd0);

    for (int i = 0; i < 8; i++) push(7, f3(ONE, HALF, MONE));
    wait_idle(n);
    checks++;
    if (n < 7 * (LAT + 2) + (LAT + 1) - 7) begin
      errors++;
      $display("FAIL same_id_spacing: drained %0d cycles after last push, required >= %0d",
               n, 7 * (LAT + 2) + (LAT + 1) - 7);
    end
    rd(7, f3(32'h41000000, 32'h40800000, 32'hC1000000));

    // RNE ties, exact cancellation to +0, and a flushed denormal addend
    push(20, f3(ONE, THREE, ONE));
    push(20, f3(32'h33800000, MONE, 32'hBF400000));
    push(20, f3(32'h34400000, MTWO, 32'h00000001));
    wait_idle(n);
    rd(20, f3(32'h3F800002, 32'h00000000, 32'h3E800000));

    saw_full = 1'b0;
    for (int id = 0; id < 16; id++)
      push(id, f3(int2f(id), int2f(16 + id), int2f(id + 1) | 32'h80000000));
    wait_idle(n);
    checks++;
    if (n != LAT + 2) begin
      errors++;
      $display("FAIL distinct_throughput: drained %0d cycles after last push, required %0d", n, LAT + 2);
    end
    chk1("distinct_no_full", saw_full, 1'b0);
    for (int id = 0; id < 16; id++)
      rd(id, f3(int2f(id), int2f(16 + id), int2f(id + 1) | 32'h80000000));

    chk1("pre_overflow_clear", o_overflow, 1'b0);
    saw_full = 1'b0;
    for (int i = 0; i < 40; i++) push(9, f3(ONE, MONE, 32'd0));
    chk1("overflow_full_seen", saw_full, 1'b1);
    chk1("overflow_latched", o_overflow, 1'b1);
    wait_idle(n);
    chk1("overflow_sticky", o_overflow, 1'b1);
    // 20 pushes fill the queue, then one slot frees every 5 cycles: 24 accepted
    rd(9, f3(32'h41C00000, 32'hC1C00000, 32'd0));

    for (int i = 0; i < 4; i++) push(11, f3(ONE, ONE, ONE));
    chk1("pre_arst_busy", o_idle, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk1("arst_idle", o_idle, 1'b1);
    chk1("arst_rd_ready", o_rd_ready, 1'b1);
    chk1("arst_overflow", o_overflow, 1'b0);
    chk1("arst_fifo_full", o_fifo_full, 1'b0);
    chk1("arst_rd_valid", o_rd_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(11, 96'd0);
    rd(9, 96'd0);
    rd(3, 96'd0);
    rd(20, 96'd0);
    repeat (3) @(negedge clk);
    chk1("post_arst_idle", o_idle, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: %0d reads outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
